// File: rtl/ss_corr_channel_if.sv
// Register-bus bundle for the correlator channel on the FE00_xxxx bus.
interface ss_corr_channel_if;
  logic [31:0] addr;
  logic [31:0] Wdata;
  logic        write;
  logic        read;
  logic [31:0] Rdata;

  modport master (output addr, Wdata, write, read, input Rdata);
  modport slave  (input addr, Wdata, write, read, output Rdata);
endinterface

// File: rtl/ss_corr_channel.sv
// Single-channel spread-spectrum correlator: NCO carrier + Galois-LFSR PRN
// wiped off the ADC stream into a saturating accumulator dumped per code epoch.

// Quarter-wave magnitude as the parabola v*(2N-v)/N, N=8192, scaled to 16 bits.
module sine (
  input  logic [12:0] v,
  output logic [15:0] sv
);
  logic [14:0] cv;
  logic [25:0] p;
  assign cv = 15'd16384 - {2'b00, v};
  assign p  = {13'd0, v} * {11'd0, cv};
  assign sv = 16'(p >> 10);
endmodule

module ss_corr_channel #(
  parameter int          ADC_W       = 16,
  parameter int          LFSR_W      = 14,
  parameter int          ACC_W       = 64,
  parameter logic [31:0] BASE        = 32'hFE000200,
  parameter int          EPOCH_STATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ss_corr_channel_if.slave        bus,
  input  logic signed [ADC_W-1:0] ADC,
  input  logic                    PushADC,
  output logic                    corr_seen
);
  localparam int PW = ADC_W + 17;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic              hit, wr, rd_stat;
  logic [5:0]        off;
  logic [2:0]        ctrl, status;
  logic [31:0]       freq_add, freq_phase, freq_adj;
  logic [31:0]       chip_freq, chip_phase, chip_adj;
  logic [31:0]       sample_cnt, epoch_cnt;
  logic [LFSR_W-1:0] prn_poly, prn_state;
  logic [4:0]        prn_hob;
  logic signed [ACC_W-1:0] acc, corr;

  assign hit     = bus.addr[31:6] == BASE[31:6];
  assign off     = bus.addr[5:0];
  assign wr      = bus.write && hit;
  assign rd_stat = bus.read && hit && off == 6'h38;

  // stage 0: NCO / chip NCO / LFSR
  logic              push, chip_c, chip_edge, epoch_tag;
  logic [31:0]       freq_nxt, chip_nxt, state_ext;
  logic [LFSR_W-1:0] state_clr, lfsr_nxt;

  assign push      = PushADC && ctrl[0];
  assign freq_nxt  = freq_phase + freq_adj + freq_add;
  assign chip_nxt  = chip_phase + chip_adj + chip_freq;
  assign chip_edge = push && !chip_phase[31] && chip_nxt[31];
  assign state_ext = 32'(prn_state);
  assign chip_c    = state_ext[prn_hob];
  assign state_clr = prn_state & ~(LFSR_W'(1) << prn_hob);
  assign lfsr_nxt  = (state_clr << 1) ^ (chip_c ? prn_poly : '0);
  assign epoch_tag = chip_edge && (lfsr_nxt == LFSR_W'(EPOCH_STATE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl       <= '0;
      freq_add   <= '0;
      freq_phase <= '0;
      freq_adj   <= '0;
      chip_freq  <= '0;
      chip_phase <= '0;
      chip_adj   <= '0;
      prn_poly   <= '0;
      prn_state  <= '0;
      prn_hob    <= '0;
      sample_cnt <= '0;
    end else begin
      if (push) begin
        sample_cnt <= sample_cnt + 32'd1;
        freq_phase <= freq_nxt;
        freq_adj   <= '0;
        chip_phase <= chip_nxt;
        chip_adj   <= '0;
        if (chip_edge) prn_state <= lfsr_nxt;
      end
      // bus writes are last so they override same-cycle push updates
      if (wr) begin
        case (off)
          6'h00: ctrl       <= bus.Wdata[2:0];
          6'h04: freq_add   <= bus.Wdata;
          6'h08: freq_phase <= bus.Wdata;
          6'h0C: freq_adj   <= bus.Wdata;
          6'h10: chip_freq  <= bus.Wdata;
          6'h14: chip_phase <= bus.Wdata;
          6'h18: chip_adj   <= bus.Wdata;
          6'h1C: prn_poly   <= bus.Wdata[LFSR_W-1:0];
          6'h20: prn_state  <= bus.Wdata[LFSR_W-1:0];
          6'h24: prn_hob    <= bus.Wdata[4:0];
          6'h28: sample_cnt <= bus.Wdata;
          default: ;
        endcase
      end
    end
  end

  // stages 1..3: carrier, PRN wipe-off, product
  logic [3:0]              vld_pipe;
  logic signed [ADC_W-1:0] smp0, smp1, smp2;
  logic [12:0]             v0;
  logic                    neg0, c0, sm0, c1;
  logic                    ep0, ep1, ep2, ep3;
  logic [31:0]             cnt0, cnt1, cnt2, cnt3;
  logic [15:0]             sv;
  logic signed [16:0]      mag, car1, car2;
  logic signed [PW-1:0]    prod3;

  sine u_sine (.v(v0), .sv(sv));
  assign mag = sm0 ? 17'sd1 : $signed({1'b0, sv});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      smp0 <= '0; smp1 <= '0; smp2 <= '0;
      v0 <= '0; neg0 <= 1'b0; c0 <= 1'b0; sm0 <= 1'b0; c1 <= 1'b0;
      ep0 <= 1'b0; ep1 <= 1'b0; ep2 <= 1'b0; ep3 <= 1'b0;
      cnt0 <= '0; cnt1 <= '0; cnt2 <= '0; cnt3 <= '0;
      car1 <= '0; car2 <= '0; prod3 <= '0;
    end else begin
      vld_pipe <= {vld_pipe[2:0], push};
      if (push) begin
        smp0 <= ADC;
        neg0 <= freq_phase[31];
        v0   <= freq_phase[30] ? ~freq_phase[29:17] : freq_phase[29:17];
        c0   <= chip_c;
        sm0  <= ctrl[1];
        ep0  <= epoch_tag;
        cnt0 <= sample_cnt + 32'd1;
      end
      if (vld_pipe[0]) begin
        smp1 <= smp0; c1 <= c0; ep1 <= ep0; cnt1 <= cnt0;
        car1 <= neg0 ? -mag : mag;
      end
      if (vld_pipe[1]) begin
        smp2 <= smp1; ep2 <= ep1; cnt2 <= cnt1;
        car2 <= c1 ? -car1 : car1;
      end
      if (vld_pipe[2]) begin
        prod3 <= PW'(smp2) * PW'(car2);
        ep3   <= ep2;
        cnt3  <= cnt2;
      end
    end
  end

  // stage 4: accumulate, saturate, dump
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    ovf, dump, sat_ev;

  assign sum    = (ACC_W+1)'(acc) + (ACC_W+1)'(prod3);
  assign ovf    = sum[ACC_W] ^ sum[ACC_W-1];
  assign dump   = vld_pipe[3] && ep3;
  assign sat_ev = vld_pipe[3] && ovf && ctrl[2];

  always_comb begin
    acc_nxt = sum[ACC_W-1:0];
    if (ovf && ctrl[2]) acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      corr      <= '0;
      epoch_cnt <= '0;
      status    <= '0;
    end else begin
      if (vld_pipe[3]) begin
        if (ep3) begin
          corr      <= acc_nxt;
          acc       <= '0;
          epoch_cnt <= cnt3;
        end else begin
          acc <= acc_nxt;
        end
      end
      // set beats read-clear; overrun looks at DUMP before the clear
      status[0] <= dump | (status[0] & ~rd_stat);
      status[1] <= (dump & status[0]) | (status[1] & ~rd_stat);
      status[2] <= sat_ev | (status[2] & ~rd_stat);
    end
  end

  assign corr_seen = status[0];

  logic signed [63:0] corr64;
  logic [31:0]        rdata;
  assign corr64 = 64'(corr);

  always_comb begin
    rdata = '0;
    if (rst && bus.read && hit) begin
      case (off)
        6'h00: rdata = {29'd0, ctrl};
        6'h04: rdata = freq_add;
        6'h08: rdata = freq_phase;
        6'h0C: rdata = freq_adj;
        6'h10: rdata = chip_freq;
        6'h14: rdata = chip_phase;
        6'h18: rdata = chip_adj;
        6'h1C: rdata = 32'(prn_poly);
        6'h20: rdata = 32'(prn_state);
        6'h24: rdata = {27'd0, prn_hob};
        6'h28: rdata = sample_cnt;
        6'h2C: rdata = epoch_cnt;
        6'h30: rdata = corr64[31:0];
        6'h34: rdata = corr64[63:32];
        6'h38: rdata = {29'd0, status};
        default: rdata = '0;
      endcase
    end
  end
  assign bus.Rdata = rdata;

endmodule

// File: tb/tb_ss_corr_channel.sv
// Randomised + directed bench for ss_corr_channel against a transaction-level model.
module tb_ss_corr_channel;
  localparam int          ADC_W  = 16;
  localparam int          LFSR_W = 4;
  localparam int          ACC_W  = 40;
  localparam logic [31:0] BASE   = 32'hFE000200;
  localparam longint      AMAX   = (64'sd1 <<< 39) - 1;
  localparam longint      AMIN   = -(64'sd1 <<< 39);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [ADC_W-1:0] adc = '0;
  logic push = 1'b0;
  logic corr_seen;

  ss_corr_channel_if bus ();

  ss_corr_channel #(.ADC_W(ADC_W), .LFSR_W(LFSR_W), .ACC_W(ACC_W), .BASE(BASE), .EPOCH_STATE(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ADC(adc), .PushADC(push), .corr_seen(corr_seen));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // model state: register file, accumulator, and in-flight products due at a cycle
  typedef struct { int due; longint prod; bit ep; logic [31:0] cnt; } ent_t;
  ent_t pq[$];
  int          m_cyc;
  logic [2:0]  m_ctrl, m_stat;
  logic [31:0] m_fadd, m_fph, m_fadj, m_cfreq, m_cph, m_cadj, m_scnt, m_ecnt;
  logic [3:0]  m_poly, m_state;
  logic [4:0]  m_hob;
  longint      m_acc, m_corr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_cyc = 0; m_ctrl = 0; m_stat = 0; m_fadd = 0; m_fph = 0; m_fadj = 0;
    m_cfreq = 0; m_cph = 0; m_cadj = 0; m_scnt = 0; m_ecnt = 0;
    m_poly = 0; m_state = 0; m_hob = 0; m_acc = 0; m_corr = 0;
  endtask

  function automatic longint wrap40(input longint x);
    logic [39:0] t;
    t = x[39:0];
    return longint'($signed(t));
  endfunction

  function automatic logic [31:0] m_rdata();
    if (!rst || !bus.read || bus.addr[31:6] != BASE[31:6]) return 32'd0;
    case (bus.addr[5:0])
      6'h00: return {29'd0, m_ctrl};
      6'h04: return m_fadd;
      6'h08: return m_fph;
      6'h0C: return m_fadj;
      6'h10: return m_cfreq;
      6'h14: return m_cph;
      6'h18: return m_cadj;
      6'h1C: return {28'd0, m_poly};
      6'h20: return {28'd0, m_state};
      6'h24: return {27'd0, m_hob};
      6'h28: return m_scnt;
      6'h2C: return m_ecnt;
      6'h30: return m_corr[31:0];
      6'h34: return m_corr[63:32];
      6'h38: return {29'd0, m_stat};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge, using the inputs the DUT will sample.
  task automatic model_step();
    ent_t e;
    longint sum, car, prod;
    int v, sv, s;
    bit c, edge_, ep, dump, satev, clr, hit;
    logic [31:0] nf, nc;
    logic [2:0] o;
    if (!rst) begin model_reset(); return; end
    m_cyc++;
    dump = 0; satev = 0;
    if (pq.size() > 0 && pq[0].due == m_cyc) begin
      e = pq.pop_front();
      sum = m_acc + e.prod;
      if (sum > AMAX || sum < AMIN) begin
        if (m_ctrl[2]) begin sum = (sum > AMAX) ? AMAX : AMIN; satev = 1; end
        else sum = wrap40(sum);
      end
      if (e.ep) begin m_corr = sum; m_acc = 0; m_ecnt = e.cnt; dump = 1; end
      else m_acc = sum;
    end
    if (push && m_ctrl[0]) begin
      v = int'(m_fph[29:17]);
      if (m_fph[30]) v = 8191 - v;
      sv = (v * (16384 - v)) / 1024;
      car = m_ctrl[1] ? 1 : sv;
      if (m_fph[31]) car = -car;
      c = ((int'(m_state) >> m_hob) & 1) != 0;
      if (c) car = -car;
      prod = longint'(adc) * car;
      m_scnt = m_scnt + 1;
      nf = m_fph + m_fadj + m_fadd;
      nc = m_cph + m_cadj + m_cfreq;
      edge_ = !m_cph[31] && nc[31];
      m_fph = nf; m_fadj = 0; m_cph = nc; m_cadj = 0;
      ep = 0;
      if (edge_) begin
        s = int'(m_state) & ~(1 << m_hob);
        s = ((s << 1) ^ (c ? int'(m_poly) : 0)) & 15;
        m_state = 4'(s);
        ep = (s == 1);
      end
      pq.push_back('{m_cyc + 4, prod, ep, m_scnt});
    end
    hit = bus.addr[31:6] == BASE[31:6];
    clr = bus.read && hit && bus.addr[5:0] == 6'h38;
    o = m_stat;
    m_stat[0] = dump | (o[0] & ~clr);
    m_stat[1] = (dump & o[0]) | (o[1] & ~clr);
    m_stat[2] = satev | (o[2] & ~clr);
    if (bus.write && hit) begin
      case (bus.addr[5:0])
        6'h00: m_ctrl  = bus.Wdata[2:0];
        6'h04: m_fadd  = bus.Wdata;
        6'h08: m_fph   = bus.Wdata;
        6'h0C: m_fadj  = bus.Wdata;
        6'h10: m_cfreq = bus.Wdata;
        6'h14: m_cph   = bus.Wdata;
        6'h18: m_cadj  = bus.Wdata;
        6'h1C: m_poly  = bus.Wdata[3:0];
        6'h20: m_state = bus.Wdata[3:0];
        6'h24: m_hob   = bus.Wdata[4:0];
        6'h28: m_scnt  = bus.Wdata;
        default: ;
      endcase
    end
  endtask

  // One cycle: compare outputs against the model mid-cycle, then step both.
  task automatic tick(input bit lit = 0, input logic [31:0] exp = 0, input string nm = "");
    @(negedge clk);
    chk("corr_seen", {31'd0, corr_seen}, {31'd0, m_stat[0]});
    chk($sformatf("rdata@%h", bus.addr), bus.Rdata, m_rdata());
    if (lit) chk(nm, bus.Rdata, exp);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] off, input logic [31:0] d);
    bus.addr = BASE + 32'(off); bus.Wdata = d; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] off, input logic [31:0] exp, input string nm);
    bus.addr = BASE + 32'(off); bus.read = 1'b1;
    tick(1, exp, nm);
    bus.read = 1'b0;
  endtask

  task automatic pushs(input logic [15:0] s);
    adc = s; push = 1'b1;
    tick();
    push = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
  endtask

  task automatic force_epoch(input logic [15:0] s);
    wr(6'h20, 32'h9);
    wr(6'h14, 32'h7FFFFFFF);
    wr(6'h10, 32'h1);
    pushs(s);
  endtask

  initial begin
    bus.addr = '0; bus.Wdata = '0; bus.write = 1'b0; bus.read = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    bus.read = 1'b1; bus.addr = BASE + 32'h38;
    tick(1, 32'd0, "status_in_reset");
    bus.read = 1'b0;
    rst = 1'b1;

    for (int k = 0; k < 15; k++) rd(6'(k * 4), 32'd0, "reset_value");
    rd(6'h3C, 32'd0, "unmapped");
    wr(6'h00, 32'h1);
    bus.addr = BASE; tick(1, 32'd0, "read_low");
    rd(6'h00, 32'h1, "ctrl_rb");

    // sine carrier, single-sample epoch, chip=1 negates
    wr(6'h1C, 32'h3); wr(6'h24, 32'h3); wr(6'h08, 32'h20000000);
    force_epoch(16'd1000);
    idle(5);
    rd(6'h30, 32'hFD120000, "corr_lo_sine");
    rd(6'h34, 32'hFFFFFFFF, "corr_hi_sine");
    rd(6'h2C, 32'd1, "epoch_cnt_1");
    rd(6'h20, 32'h1, "state_epoch");
    rd(6'h38, 32'h1, "status_dump");
    rd(6'h38, 32'h0, "status_cleared");

    // LFSR sequence 8 -> 3,6,C,B ... 1, chip edges every other push
    wr(6'h20, 32'h8); wr(6'h14, 32'h0); wr(6'h10, 32'h80000000);
    pushs(16'($urandom)); rd(6'h20, 32'h3, "lfsr_3");
    pushs(16'($urandom)); pushs(16'($urandom)); rd(6'h20, 32'h6, "lfsr_6");
    pushs(16'($urandom)); pushs(16'($urandom)); rd(6'h20, 32'hC, "lfsr_c");
    pushs(16'($urandom)); pushs(16'($urandom)); rd(6'h20, 32'hB, "lfsr_b");
    for (int i = 0; i < 16; i++) pushs(16'($urandom));
    idle(5);
    rd(6'h2C, 32'd24, "epoch_cnt_lfsr");

    // overrun, then read-coinciding-with-dump
    force_epoch(16'd500);
    idle(5);
    rd(6'h38, 32'h3, "status_overrun");
    rd(6'h38, 32'h0, "status_clr2");
    force_epoch(16'd7);
    idle(5);
    force_epoch(16'd9);
    idle(3);
    rd(6'h38, 32'h1, "status_pre_dump");
    rd(6'h38, 32'h3, "status_set_wins");
    rd(6'h38, 32'h0, "status_clr3");

    // write beats push increment; one-shot adj consumed once
    wr(6'h04, 32'h10); wr(6'h0C, 32'h100);
    bus.addr = BASE + 32'h08; bus.Wdata = 32'h12345678; bus.write = 1'b1;
    adc = 16'd1; push = 1'b1;
    tick();
    bus.write = 1'b0; push = 1'b0;
    rd(6'h08, 32'h12345678, "phase_write_wins");
    rd(6'h0C, 32'h0, "adj_consumed");
    pushs(16'd1);
    rd(6'h08, 32'h12345688, "phase_after_push");
    bus.addr = BASE + 32'h28; bus.Wdata = 32'd100; bus.write = 1'b1; push = 1'b1;
    tick();
    bus.write = 1'b0; push = 1'b0;
    rd(6'h28, 32'd100, "scnt_write_wins");
    idle(5);

    // saturation at 2^39-1, then wrap with SAT_EN=0
    do_reset();
    wr(6'h00, 32'h5); wr(6'h08, 32'h3FFE0000);
    for (int i = 0; i < 300; i++) pushs(16'h7FFF);
    wr(6'h1C, 32'h3); wr(6'h24, 32'h3);
    force_epoch(16'd0);
    idle(5);
    rd(6'h30, 32'hFFFFFFFF, "sat_lo");
    rd(6'h34, 32'h0000007F, "sat_hi");
    rd(6'h38, 32'h5, "sat_status");
    wr(6'h00, 32'h1); wr(6'h10, 32'h0);
    for (int i = 0; i < 300; i++) pushs(16'h7FFF);
    force_epoch(16'd0);
    idle(5);
    rd(6'h34, 32'hFFFFFF95, "wrap_hi");

    // randomised traffic with a mid-run reset
    wr(6'h04, $urandom); wr(6'h10, $urandom);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        wr(6'h00, 32'h1); wr(6'h1C, 32'h3); wr(6'h24, 32'h3); wr(6'h10, $urandom);
      end
      push = ($urandom_range(0, 9) < 7);
      adc = (i % 97 == 0) ? 16'h8000 : 16'($urandom);
      bus.write = ($urandom_range(0, 9) == 0);
      bus.read = ($urandom_range(0, 9) < 3);
      if (bus.write) begin
        bus.addr = BASE + 32'($urandom_range(0, 14) * 4);
        case (bus.addr[5:0])
          6'h00:   bus.Wdata = {29'd0, 3'($urandom) | 3'(($urandom_range(0, 9) != 0) ? 1 : 0)};
          6'h24:   bus.Wdata = 32'($urandom_range(0, 3));
          default: bus.Wdata = $urandom;
        endcase
      end else if ($urandom_range(0, 19) == 0) begin
        bus.addr = BASE + 32'h40;
      end else begin
        bus.addr = BASE + 32'($urandom_range(0, 15) * 4);
      end
      tick();
    end
    push = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ss_corr_channel.md
# ss_corr_channel

Parametrised single-channel spread-spectrum correlator. It generalises the fixed 16-bit correlator channel with configurable ADC, LFSR and accumulator widths, a base address, a selectable carrier mode, saturating accumulation, and dump-overrun detection. It sits on the FE00_xxxx register bus beside the other correlator channels. It consumes the shared ADC sample stream and raises `corr_seen` to the channel aggregator when an epoch dump is ready.

## Interface
- `ADC_W`, 16: signed ADC sample width (8..16).
- `LFSR_W`, 14: PRN Galois LFSR width (4..31).
- `ACC_W`, 64: signed accumulator width (40..64).
- `BASE`, 32'hFE000200: register block base address, 64-byte aligned.
- `EPOCH_STATE`, 1: LFSR state value that marks code epoch.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `addr` in 32: bus address.
- `Wdata` in 32: write data.
- `write` in 1: write strobe, single cycle.
- `read` in 1: read strobe.
- `Rdata` out 32: combinational read data. Equals 0 when `read`=0, when the address is unmapped, or while in reset.
- `ADC` in ADC_W: signed sample, valid with `PushADC`.
- `PushADC` in 1: sample strobe.
- `corr_seen` out 1: equals STATUS[0].
- `sine` (13-bit `v` → 16-bit `sv` quarter-wave magnitude) is instantiated internally.

## Operation
Register map, offsets from BASE. All registers are R/W unless noted.
- 0x00 CTRL: bit0 EN, bit1 SIGN_MODE, bit2 SAT_EN.
- 0x04 FREQ_ADD.
- 0x08 FREQ_PHASE.
- 0x0C FREQ_ADJ: one-shot, cleared after it is consumed.
- 0x10 CHIP_FREQ.
- 0x14 CHIP_PHASE.
- 0x18 CHIP_ADJ: one-shot.
- 0x1C PRN_POLY[LFSR_W-1:0].
- 0x20 PRN_STATE[LFSR_W-1:0].
- 0x24 PRN_HOB[4:0]: tap index, must be < LFSR_W.
- 0x28 SAMPLE_CNT.
- 0x2C EPOCH_CNT (RO).
- 0x30 CORR_LO (RO).
- 0x34 CORR_HI (RO): sign-extended to 32 bits above ACC_W.
- 0x38 STATUS (RO, read-to-clear): bit0 DUMP, bit1 OVERRUN, bit2 SAT.

Stage 0 runs on `PushADC`=1 with EN=1. Pushes with EN=0 are ignored entirely.
- SAMPLE_CNT increments by 1.
- FREQ_PHASE ← FREQ_PHASE + FREQ_ADJ + FREQ_ADD, then FREQ_ADJ ← 0. CHIP_PHASE updates the same way from CHIP_ADJ and CHIP_FREQ. All additions are mod 2^32.
- Capture: sample, quadrant q = FREQ_PHASE[31:30] (pre-update), `v` = FREQ_PHASE[29:17] (inverted when q[0]=1), chip c = PRN_STATE[PRN_HOB].
- Chip edge: the pre-update CHIP_PHASE[31]=0 and the post-update value is 1.
- On a chip edge the LFSR advances: s' = ((s with bit HOB cleared) << 1), XOR POLY if c=1, truncated to LFSR_W bits.
- Epoch tag: chip edge AND s' == EPOCH_STATE.

Pipeline stages:
- Stage 1: carrier = q[1] ? −sv : sv, as 17-bit signed. In SIGN_MODE the carrier is q[1] ? −1 : +1.
- Stage 2: carrier negated if c=1.
- Stage 3: product = sample × carrier, ADC_W+17 bits signed.
- Stage 4: ACC ← ACC + sign-extended product.
  - With SAT_EN=1, overflow clamps ACC to the signed max or min and sets STATUS[2].
  - With SAT_EN=0, ACC wraps.

Epoch dump, when an epoch-tagged sample reaches stage 4:
- CORR ← ACC including this sample's product.
- ACC ← 0.
- EPOCH_CNT ← the SAMPLE_CNT value after that sample's increment.
- STATUS[1] is set if STATUS[0] was already 1.
- STATUS[0] is set.

## Timing
- Reset (`rst`=0) clears every register, the accumulator, all pipeline valids and LFSR state, immediately. `Rdata`=0 and `corr_seen`=0.
- A reset mid-epoch discards in-flight samples; there are no partial dumps.
- Pipeline latency: a sample pushed at edge N is accumulated at edge N+4. CORR and STATUS update at N+4, and `corr_seen` rises after N+4.
- Back-to-back pushes are allowed every cycle. Each stage advances only with its own valid bit; gaps insert bubbles.
- A bus write lands at the clock edge. If a push updates the same register in the same cycle, the write wins and the push increment for that register is lost.
- A write to PRN_STATE on a chip-edge cycle overrides the LFSR advance.
- A STATUS read clears the bits at the next edge. If a dump occurs in the same cycle, the set wins (DUMP=1), and OVERRUN is evaluated against the pre-clear value.
- Phase wrap 0xFFFFFFFF→0 is a normal modulo wrap. It is never a chip edge, because bit31 goes 1→0.

## Test plan
- Reset, then read every offset → all 0. Unmapped BASE+0x3C → 0. `read`=0 → `Rdata`=0.
- Sine mode, constant sample +1000: FREQ_ADD=0, FREQ_PHASE=0x20000000 (v=0x1000) → product = 1000·sv(0x1000), accumulated 4 cycles after the push.
- Set LFSR_W=4, POLY=0x3, HOB=3, STATE=0x8, CHIP_FREQ=0x80000000 → state sequence 0x3, 0x6, 0xC, 0xB… The epoch fires when the state hits 1, and CORR and EPOCH_CNT match the model.
- Force two epochs without reading STATUS → STATUS=0x3. After one read → 0. A read coinciding with a dump → STATUS[0]=1.
- ACC_W=40, SAT_EN=1, ADC=0x7FFF, SIGN_MODE=1 for 2^24+ samples → ACC clamps at 2^39−1 and STATUS[2]=1. With SAT_EN=0 the accumulator wraps negative.
- Write FREQ_PHASE on a push cycle → the written value holds, and FREQ_ADJ is consumed exactly once.
